// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues req/gnt/rvalid transactions on the data-memory
// port, stalls the pipeline while one is outstanding and extends loaded data.
module mem_access_unit #(
  parameter int unsigned WORD_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_valid,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [2:0]          funct3,
  input  logic [WORD_LEN-1:0] ALURes,
  input  logic [WORD_LEN-1:0] store_data,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [WORD_LEN-1:0] dmem_addr,
  output logic [3:0]          dmem_be,
  output logic [WORD_LEN-1:0] dmem_wdata,
  input  logic                dmem_gnt,
  input  logic                dmem_rvalid,
  input  logic [WORD_LEN-1:0] dmem_rdata,
  output logic [WORD_LEN-1:0] Mem_Data,
  output logic                stall,
  output logic                misalign
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t              state;
  state_t              state_next;
  size_t               size_c;
  size_t               ld_size;
  logic                ld_unsigned;
  logic [1:0]          lane;
  logic                access;
  logic                aligned;
  logic                start;
  logic [3:0]          be_c;
  logic [WORD_LEN-1:0] wdata_c;
  logic [BYTE_W-1:0]   rbyte;
  logic [HALF_W-1:0]   rhalf;
  logic [WORD_LEN-1:0] load_ext;

  // Access size: stores only know SB/SH/SW, loads ignore the unsigned bit for sizing
  always_comb begin
    size_c = SZ_W;
    if (MemWrite) begin
      if (funct3 == 3'b000)      size_c = SZ_B;
      else if (funct3 == 3'b001) size_c = SZ_H;
    end else begin
      if (funct3[1:0] == 2'b00)      size_c = SZ_B;
      else if (funct3[1:0] == 2'b01) size_c = SZ_H;
    end
  end

  always_comb begin
    access  = mem_valid & (MemRead | MemWrite);
    aligned = (size_c == SZ_B) |
              ((size_c == SZ_H) & ~ALURes[0]) |
              ((size_c == SZ_W) & (ALURes[1:0] == 2'b00));
    start   = (state == IDLE) & access & aligned;
  end

  // Byte enables and lane-replicated write data for the request being started
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = '0;
    case (size_c)
      SZ_B:    be_c = 4'b0001 << ALURes[1:0];
      SZ_H:    be_c = ALURes[1] ? 4'b1100 : 4'b0011;
      default: be_c = 4'b1111;
    endcase
    if (MemWrite) begin
      case (size_c)
        SZ_B:    wdata_c = {4{store_data[BYTE_W-1:0]}};
        SZ_H:    wdata_c = {2{store_data[HALF_W-1:0]}};
        default: wdata_c = store_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start)       state_next = REQ;
      REQ:  if (dmem_gnt)    state_next = dmem_we ? DONE : RESP;
      RESP: if (dmem_rvalid) state_next = DONE;
      DONE:                  state_next = IDLE;
    endcase
  end

  // Pipeline-facing strobes are forced low while reset is asserted
  always_comb begin
    stall    = 1'b0;
    misalign = 1'b0;
    if (rst_n) begin
      stall    = start | (state == REQ) | (state == RESP);
      misalign = (state == IDLE) & access & ~aligned;
    end
  end

  // Lane select uses the byte offset captured with the request
  always_comb begin
    rbyte = dmem_rdata[7:0];
    case (lane)
      2'd1:    rbyte = dmem_rdata[15:8];
      2'd2:    rbyte = dmem_rdata[23:16];
      2'd3:    rbyte = dmem_rdata[31:24];
      default: rbyte = dmem_rdata[7:0];
    endcase
    rhalf = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (ld_size)
      SZ_B:    load_ext = ld_unsigned ? {24'd0, rbyte} : {{24{rbyte[BYTE_W-1]}}, rbyte};
      SZ_H:    load_ext = ld_unsigned ? {16'd0, rhalf} : {{16{rhalf[HALF_W-1]}}, rhalf};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= '0;
      dmem_wdata  <= '0;
      Mem_Data    <= '0;
      ld_size     <= SZ_W;
      ld_unsigned <= 1'b0;
      lane        <= 2'd0;
    end else begin
      if (start) begin
        dmem_req    <= 1'b1;
        dmem_we     <= MemWrite;
        dmem_addr   <= {ALURes[WORD_LEN-1:2], 2'b00};
        dmem_be     <= be_c;
        dmem_wdata  <= wdata_c;
        ld_size     <= size_c;
        ld_unsigned <= funct3[2];
        lane        <= ALURes[1:0];
      end else if ((state == REQ) && dmem_gnt) begin
        dmem_req <= 1'b0;
      end
      if ((state == RESP) && dmem_rvalid) Mem_Data <= load_ext;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// load/store traffic compared against a byte-lane arithmetic reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALURes;
  logic [31:0] store_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] Mem_Data;
  logic        stall;
  logic        misalign;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] last_load = 32'd0;

  typedef struct {
    int          stalls;
    int          cycles;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    logic [3:0]  be;
    logic        we;
    logic        stable;
    logic        req_ok;
  } obs_t;

  mem_access_unit #(.WORD_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .MemRead(MemRead),
    .MemWrite(MemWrite), .funct3(funct3), .ALURes(ALURes), .store_data(store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .Mem_Data(Mem_Data), .stall(stall), .misalign(misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: access width in bytes
  function automatic int acc_bytes(input logic wr, input logic [2:0] f3);
    if (wr) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_aligned(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) % acc_bytes(wr, f3)) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] m;
    m = 4'((32'd1 << acc_bytes(wr, f3)) - 32'd1);
    return m << int'(a[1:0]);
  endfunction

  function automatic logic [31:0] m_wdata(input logic wr, input logic [2:0] f3, input logic [31:0] sd);
    int n;
    logic [31:0] unit, r;
    if (!wr) return 32'd0;
    n = acc_bytes(wr, f3);
    unit = (n == 4) ? sd : (sd & ((32'd1 << (8 * n)) - 32'd1));
    r = 32'd0;
    for (int k = 0; k < 4 / n; k++) r = r | (unit << (8 * n * k));
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int n;
    logic [31:0] v, mask;
    n = acc_bytes(1'b0, f3);
    v = rd >> (8 * int'(a[1:0]));
    if (n < 4) begin
      mask = (32'd1 << (8 * n)) - 32'd1;
      v = v & mask;
      if (!f3[2] && v[8 * n - 1]) v = v | ~mask;
    end
    return v;
  endfunction

  // Drives one aligned access through the memory port with the given wait counts.
  // Enters and returns just after a rising edge; the command stays on the inputs.
  task automatic do_access(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rd,
                           input int gw, input int rw, output obs_t o);
    int phase;
    int waited;
    logic first;
    mem_valid = 1'b1; MemRead = ~wr; MemWrite = wr; funct3 = f3; ALURes = a; store_data = sd;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    o.stalls = 0; o.cycles = 0; o.addr = '0; o.wdata = '0; o.mdata = '0; o.be = '0;
    o.we = 1'b0; o.stable = 1'b1; o.req_ok = 1'b1;
    phase = 0; waited = 0; first = 1'b1;
    for (int c = 0; c < 64 && phase != 4; c++) begin
      dmem_gnt    = (phase == 1) && (waited == gw);
      dmem_rvalid = ((phase == 2) && (waited == rw)) || ((phase == 3) && ($urandom_range(0, 1) == 1));
      dmem_rdata  = ((phase == 2) && dmem_rvalid) ? rd : $urandom;
      @(negedge clk);
      o.cycles++;
      if (stall) o.stalls++;
      if (dmem_req !== (phase == 1)) o.req_ok = 1'b0;
      if (phase == 1) begin
        if (first) begin
          o.addr = dmem_addr; o.be = dmem_be; o.wdata = dmem_wdata; o.we = dmem_we; first = 1'b0;
        end else if (dmem_addr !== o.addr || dmem_be !== o.be || dmem_wdata !== o.wdata || dmem_we !== o.we) begin
          o.stable = 1'b0;
        end
      end
      if (phase == 3) o.mdata = Mem_Data;
      @(posedge clk); #1;
      case (phase)
        0: phase = 1;
        1: if (dmem_gnt) begin phase = wr ? 3 : 2; waited = 0; end else waited++;
        2: if (dmem_rvalid) phase = 3; else waited++;
        default: phase = 4;
      endcase
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    vectors++;
    if (phase != 4) begin errors++; $display("FAIL access_timeout: phase %0d, expected completion", phase); end
  endtask

  task automatic idle_cycle();
    mem_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010;
    ALURes = 32'h100; store_data = 32'h0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", dmem_req); end
      vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
      vectors++; if (Mem_Data !== 32'h0) begin errors++; $display("FAIL reset_mdata: got %h expected 0", Mem_Data); end
      vectors++; if ({dmem_we, dmem_addr, dmem_be, dmem_wdata} !== '0) begin errors++;
        $display("FAIL reset_port: got we=%b addr=%h be=%b wdata=%h expected zeros", dmem_we, dmem_addr, dmem_be, dmem_wdata); end
      @(posedge clk); #1;
    end
    rst_n = 1'b1; mem_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_sb();
    obs_t o;
    do_access(1'b1, 3'b000, 32'h1003, 32'h0000_00A5, 32'h0, 0, 0, o);
    mem_valid = 1'b0;
    vectors++; if (o.addr !== 32'h1000) begin errors++; $display("FAIL sb_addr: got %h expected 00001000", o.addr); end
    vectors++; if (o.be !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b expected 1000", o.be); end
    vectors++; if (o.wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", o.wdata); end
    vectors++; if (o.we !== 1'b1) begin errors++; $display("FAIL sb_we: got %b expected 1", o.we); end
    vectors++; if (o.stalls != 2) begin errors++; $display("FAIL sb_stall_cycles: got %0d expected 2", o.stalls); end
    vectors++; if (o.req_ok !== 1'b1) begin errors++; $display("FAIL sb_req_timing: got %b expected 1", o.req_ok); end
    idle_cycle();
  endtask

  task automatic test_lh_lhu();
    obs_t o;
    logic [31:0] exp;
    for (int i = 0; i < 2; i++) begin
      exp = (i == 0) ? 32'hFFFF8001 : 32'h00008001;
      do_access(1'b0, (i == 0) ? 3'b001 : 3'b101, 32'h2002, 32'hFFFF_FFFF, 32'h8001_1234, 2, 0, o);
      last_load = exp;
      vectors++; if (o.mdata !== exp) begin errors++; $display("FAIL lh_mdata[%0d]: got %h expected %h", i, o.mdata, exp); end
      vectors++; if (o.addr !== 32'h2000 || o.be !== 4'b1100) begin errors++;
        $display("FAIL lh_addr_be[%0d]: got %h/%b expected 00002000/1100", i, o.addr, o.be); end
      vectors++; if (o.we !== 1'b0 || o.wdata !== 32'h0) begin errors++;
        $display("FAIL lh_we_wdata[%0d]: got %b/%h expected 0/00000000", i, o.we, o.wdata); end
      vectors++; if (o.stable !== 1'b1) begin errors++; $display("FAIL lh_req_stable[%0d]: got %b expected 1", i, o.stable); end
      vectors++; if (o.stalls != 5) begin errors++; $display("FAIL lh_stall_cycles[%0d]: got %0d expected 5", i, o.stalls); end
    end
    idle_cycle();
  endtask

  task automatic misaligned_cycle(input string nm, input logic wr, input logic [2:0] f3, input logic [31:0] a);
    mem_valid = 1'b1; MemRead = ~wr; MemWrite = wr; funct3 = f3; ALURes = a; store_data = $urandom;
    @(negedge clk);
    vectors++; if (misalign !== 1'b1 || stall !== 1'b0) begin errors++;
      $display("FAIL %s_pulse: got misalign=%b stall=%b expected 1/0", nm, misalign, stall); end
    @(posedge clk); #1;
    mem_valid = 1'b0;
    @(negedge clk);
    vectors++; if (dmem_req !== 1'b0 || misalign !== 1'b0 || stall !== 1'b0) begin errors++;
      $display("FAIL %s_after: got req=%b misalign=%b stall=%b expected 0/0/0", nm, dmem_req, misalign, stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_misalign();
    misaligned_cycle("mis_lw", 1'b0, 3'b010, 32'h3001);
    misaligned_cycle("mis_sh", 1'b1, 3'b001, 32'h3003);
    misaligned_cycle("mis_lhu", 1'b0, 3'b101, 32'h3005);
  endtask

  task automatic test_reset_resp();
    obs_t o;
    mem_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALURes = 32'h80;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    @(posedge clk); #1;
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    vectors++; if (stall !== 1'b0 || misalign !== 1'b0) begin errors++;
      $display("FAIL rr_strobes_in_reset: got stall=%b misalign=%b expected 0/0", stall, misalign); end
    @(posedge clk); #1;
    rst_n = 1'b1; mem_valid = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h1357_9BDF;
    @(negedge clk);
    vectors++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin errors++;
      $display("FAIL rr_req_after_reset: got req=%b stall=%b expected 0/0", dmem_req, stall); end
    vectors++; if (Mem_Data !== 32'h0) begin errors++; $display("FAIL rr_mdata_cleared: got %h expected 0", Mem_Data); end
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    vectors++; if (Mem_Data !== 32'h0) begin errors++; $display("FAIL rr_late_rvalid: got %h expected 0", Mem_Data); end
    @(posedge clk); #1;
    last_load = 32'h0;
    do_access(1'b0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 0, 0, o);
    mem_valid = 1'b0;
    last_load = 32'hDEADBEEF;
    vectors++; if (o.mdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rr_next_lw: got %h expected deadbeef", o.mdata); end
    vectors++; if (o.stalls != 3 || o.addr !== 32'h40 || o.be !== 4'b1111) begin errors++;
      $display("FAIL rr_next_lw_port: got stalls=%0d addr=%h be=%b expected 3/00000040/1111", o.stalls, o.addr, o.be); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    obs_t o;
    do_access(1'b1, 3'b010, 32'h500, 32'h11223344, 32'h0, 0, 0, o);
    vectors++; if (o.cycles != 3 || o.mdata !== last_load || o.wdata !== 32'h11223344) begin errors++;
      $display("FAIL b2b_sw: got cycles=%0d mdata=%h wdata=%h expected 3/%h/11223344", o.cycles, o.mdata, o.wdata, last_load); end
    do_access(1'b0, 3'b000, 32'h503, 32'h0, 32'h8000_0000, 0, 0, o);
    vectors++; if (o.cycles != 4 || o.mdata !== 32'hFFFFFF80 || o.be !== 4'b1000) begin errors++;
      $display("FAIL b2b_lb: got cycles=%0d mdata=%h be=%b expected 4/ffffff80/1000", o.cycles, o.mdata, o.be); end
    do_access(1'b0, 3'b100, 32'h501, 32'h0, 32'h0000_F100, 1, 1, o);
    vectors++; if (o.cycles != 6 || o.mdata !== 32'h000000F1 || o.be !== 4'b0010) begin errors++;
      $display("FAIL b2b_lbu: got cycles=%0d mdata=%h be=%b expected 6/000000f1/0010", o.cycles, o.mdata, o.be); end
    last_load = 32'h000000F1;
    idle_cycle();
  endtask

  task automatic test_random();
    obs_t o;
    logic wr;
    logic [2:0] f3;
    logic [31:0] a, sd, rd, exp_md;
    int n, gw, rw, exp_st;
    for (int t = 0; t < 60; t++) begin
      wr = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
      n = acc_bytes(wr, f3);
      a = $urandom; sd = $urandom; rd = $urandom;
      if ($urandom_range(0, 4) != 0) a = a & ~32'(n - 1);
      if (!m_aligned(wr, f3, a)) begin
        misaligned_cycle("rnd_mis", wr, f3, a);
        continue;
      end
      gw = $urandom_range(0, 3); rw = $urandom_range(0, 3);
      do_access(wr, f3, a, sd, rd, gw, rw, o);
      if (!wr) last_load = m_load(f3, a, rd);
      exp_md = last_load;
      exp_st = 1 + (gw + 1) + (wr ? 0 : rw + 1);
      vectors++; if (o.addr !== {a[31:2], 2'b00}) begin errors++; $display("FAIL rnd_addr[%0d]: got %h expected %h", t, o.addr, {a[31:2], 2'b00}); end
      vectors++; if (o.be !== m_be(wr, f3, a)) begin errors++; $display("FAIL rnd_be[%0d]: got %b expected %b", t, o.be, m_be(wr, f3, a)); end
      vectors++; if (o.wdata !== m_wdata(wr, f3, sd)) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", t, o.wdata, m_wdata(wr, f3, sd)); end
      vectors++; if (o.we !== wr) begin errors++; $display("FAIL rnd_we[%0d]: got %b expected %b", t, o.we, wr); end
      vectors++; if (o.stalls != exp_st) begin errors++; $display("FAIL rnd_stalls[%0d]: got %0d expected %0d", t, o.stalls, exp_st); end
      vectors++; if (o.req_ok !== 1'b1 || o.stable !== 1'b1) begin errors++;
        $display("FAIL rnd_req[%0d]: got timing=%b stable=%b expected 1/1", t, o.req_ok, o.stable); end
      vectors++; if (o.mdata !== exp_md) begin errors++; $display("FAIL rnd_mdata[%0d]: got %h expected %h", t, o.mdata, exp_md); end
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();
  endtask

  initial begin
    rst_n = 1'b0; mem_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b0;
    ALURes = 32'h0; store_data = 32'h0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    test_reset();
    test_sb();
    test_lh_lhu();
    test_misalign();
    test_reset_resp();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
